// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises the line, confirms the start bit at mid-bit,
// samples each data bit at bit centre and emits one-cycle byte / framing-error strobes.
module uart_byte_rx #(
  parameter longint CLOCK_FREQ = 50000000,
  parameter longint BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_rx,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = int'(CLOCK_FREQ / BAUD_RATE);
  localparam int CW           = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_byte_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_s      <= rx_meta;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  // Counter is cleared on every state change; dropping start_rx aborts any frame.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CW'(1);
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (start_rx && !rx_s) state_n = START;
      end
      START: begin
        if (!start_rx) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == HALF_CNT) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (!start_rx) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == FULL_CNT) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (!start_rx) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == FULL_CNT) begin
          cnt_n = '0;
          if (rx_s) begin
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BRK;
          end
        end
      end
      BRK: begin
        // A held-low line must not be taken for a new start bit.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_busy   = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 10 clocks per bit: vector table of frames
// plus hand-written glitch, framing-error, abort and mid-frame reset sequences.
module tb_uart_byte_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       start_rx;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic [2:0] dbg_state;

  uart_byte_rx #(
    .CLOCK_FREQ(64'd10000000000),
    .BAUD_RATE (64'd1000000000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_rx (start_rx),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = -1;
  bit spacing_on = 1'b0;
  int fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap: rx_valid=1 frame_err=1 expected not both");
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data 0x%0h expected no strobe", rx_data);
        end else begin
          check("rx_valid_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (spacing_on && last_valid_cyc >= 0)
          check_range("b2b_spacing", cyc - last_valid_cyc, CPB * 10 - 1, CPB * 10 + 1);
        last_valid_cyc = cyc;
      end
    end
  end

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;
  } vec_t;

  vec_t vecs[10];
  int   v_before;
  bit   went_idle;
  logic [7:0] abort_byte;

  initial begin
    vecs[0] = '{8'hFF, 10 * CPB};
    vecs[1] = '{8'h11, 10 * CPB};
    vecs[2] = '{8'hBB, 10 * CPB};
    vecs[3] = '{8'hEF, 10 * CPB};
    vecs[4] = '{8'hBE, 10 * CPB};
    vecs[5] = '{8'hAD, 10 * CPB};
    vecs[6] = '{8'hDE, 10 * CPB};
    vecs[7] = '{8'h01, 0};
    vecs[8] = '{8'h10, 0};
    vecs[9] = '{8'h00, 0};

    rst = 1'b1;
    start_rx = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'h0);
    rst = 1'b0;
    start_rx = 1'b1;
    tick(5);

    // table: gapped frames, then back-to-back frames
    for (int i = 0; i < 10; i++) begin
      if (i == 8) spacing_on = 1'b1;
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1);
      if (i == 0) check_range("first_latency", last_valid_cyc - fall_cyc, 97, 99);
      check("table_rx_data", {24'd0, rx_data}, {24'd0, vecs[i].data});
      uart_rx = 1'b1;
      if (vecs[i].gap > 0) tick(vecs[i].gap);
    end
    tick(20);
    spacing_on = 1'b0;
    check("table_valid_count", valid_cnt, 10);
    check("table_no_ferr", ferr_cnt, 0);

    // start-bit glitch
    v_before = valid_cnt;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    check("glitch_busy_high", {31'd0, rx_busy}, 32'h1);
    went_idle = 1'b0;
    for (int i = 0; i < 8 && !went_idle; i++) begin
      tick(1);
      if (!rx_busy) went_idle = 1'b1;
    end
    check("glitch_busy_returns", {31'd0, went_idle}, 32'h1);
    tick(10);
    check("glitch_no_valid", valid_cnt, v_before);
    check("glitch_no_ferr", ferr_cnt, 0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_then_a5", {24'd0, rx_data}, 32'hA5);

    // framing error with a held-low break
    v_before = valid_cnt;
    send_frame(8'h55, 1'b0);
    tick(30);
    check("break_busy_high", {31'd0, rx_busy}, 32'h1);
    check("ferr_count", ferr_cnt, 1);
    check("ferr_no_valid", valid_cnt, v_before);
    check("ferr_data_kept", {24'd0, rx_data}, 32'hA5);
    uart_rx = 1'b1;
    tick(4);
    check("break_released_idle", {31'd0, rx_busy}, 32'h0);
    tick(10);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    uart_rx = 1'b1;
    tick(20);
    check("after_break_3c", {24'd0, rx_data}, 32'h3C);

    // abort during data bit 4
    v_before = valid_cnt;
    abort_byte = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    uart_rx = abort_byte[4];
    tick(5);
    start_rx = 1'b0;
    tick(1);
    check("abort_idle_next", {31'd0, rx_busy}, 32'h0);
    tick(4);
    for (int i = 5; i < 8; i++) drive_bit(abort_byte[i]);
    drive_bit(1'b1);
    tick(20);
    check("abort_no_valid", valid_cnt, v_before);
    check("abort_data_kept", {24'd0, rx_data}, 32'h3C);
    start_rx = 1'b1;
    tick(5);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    uart_rx = 1'b1;
    tick(20);
    check("after_abort_77", {24'd0, rx_data}, 32'h77);

    // reset mid-frame
    v_before = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(1);
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'h0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'h0);
    check("midrst_rx_busy", {31'd0, rx_busy}, 32'h0);
    rst = 1'b0;
    tick(20);
    check("midrst_no_valid", valid_cnt, v_before);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    uart_rx = 1'b1;
    tick(20);
    check("after_reset_c3", {24'd0, rx_data}, 32'hC3);

    check("final_ferr_count", ferr_cnt, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
